// File: rtl/free_list_pkg.sv
// Shared rename definitions: register-file sizes, tag type and the reserved tag.
// Imported by the ROB, the map table and the free list.
package free_list_pkg;

    localparam int NUM_PREGS_DEF = 16;
    localparam int NUM_AREGS_DEF = 4;
    localparam int TAG_W         = 32;

    typedef logic [TAG_W-1:0] tag_t;

    // Tag 0 means "no register"; stores carry Told = TAG_NONE.
    localparam tag_t TAG_NONE = '0;

endpackage

// File: rtl/free_list_if.sv
// Free-list port bundle: allocation (show-ahead pop), two push ports and status.
// master = ROB/rename side, slave = free list.
interface free_list_if #(
    parameter int NUM_PREGS = free_list_pkg::NUM_PREGS_DEF
);
    import free_list_pkg::*;

    localparam int CNT_W = $clog2(NUM_PREGS) + 1;

    // Handshake: pr_out is valid whenever not_empty is high; a pop happens on
    // a clock edge where alloc_req && not_empty. Pushes are single-cycle strobes
    // with no back-pressure; rejected pushes only raise sticky error flags.
    logic             alloc_req;
    tag_t             pr_out;
    logic             not_empty;
    logic             retire_free_valid;
    tag_t             retire_free_tag;
    logic             rollback_free_valid;
    tag_t             rollback_free_tag;
    logic [CNT_W-1:0] free_count;
    logic             err_underflow;
    logic             err_double_free;
    logic             err_range;

    modport master (
        output alloc_req, retire_free_valid, retire_free_tag,
               rollback_free_valid, rollback_free_tag,
        input  pr_out, not_empty, free_count,
               err_underflow, err_double_free, err_range
    );

    modport slave (
        input  alloc_req, retire_free_valid, retire_free_tag,
               rollback_free_valid, rollback_free_tag,
        output pr_out, not_empty, free_count,
               err_underflow, err_double_free, err_range
    );

endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags plus an "is free"
// bitmap that rejects duplicate and out-of-range frees.
module free_list
    import free_list_pkg::*;
#(
    parameter int NUM_PREGS = NUM_PREGS_DEF,
    parameter int NUM_AREGS = NUM_AREGS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    free_list_if.slave  bus
);

    localparam int DEPTH     = NUM_PREGS - 1;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int IDX_W     = $clog2(NUM_PREGS);
    localparam int CNT_W     = $clog2(NUM_PREGS) + 1;
    localparam int RESET_CNT = NUM_PREGS - NUM_AREGS - 1;

    logic [IDX_W-1:0]     mem_q [DEPTH];
    logic [IDX_W-1:0]     mem_d [DEPTH];
    logic [NUM_PREGS-1:0] bitmap_q, bitmap_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 err_underflow_q, err_underflow_d;
    logic                 err_double_free_q, err_double_free_d;
    logic                 err_range_q, err_range_d;

    logic             pop;
    logic             r_live, r_in_range, r_dup, r_acc;
    logic             b_live, b_in_range, b_dup, b_acc;
    logic [IDX_W-1:0] r_idx, b_idx;
    logic [PTR_W-1:0] b_slot;

    // Depth is not a power of two, so the wrap is explicit.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop = bus.alloc_req && (count_q != '0);

        r_idx      = bus.retire_free_tag[IDX_W-1:0];
        r_live     = bus.retire_free_valid && (bus.retire_free_tag != TAG_NONE);
        r_in_range = bus.retire_free_tag < tag_t'(NUM_PREGS);
        r_dup      = r_live && r_in_range &&
                     (bitmap_q[r_idx] || (count_q >= CNT_W'(DEPTH)));
        r_acc      = r_live && r_in_range && !r_dup;

        // Rollback sees the retire push of the same cycle as already inserted.
        b_idx      = bus.rollback_free_tag[IDX_W-1:0];
        b_live     = bus.rollback_free_valid && (bus.rollback_free_tag != TAG_NONE);
        b_in_range = bus.rollback_free_tag < tag_t'(NUM_PREGS);
        b_dup      = b_live && b_in_range &&
                     (bitmap_q[b_idx] || (r_acc && (b_idx == r_idx)) ||
                      ((count_q + CNT_W'(r_acc)) >= CNT_W'(DEPTH)));
        b_acc      = b_live && b_in_range && !b_dup;

        mem_d    = mem_q;
        bitmap_d = bitmap_q;
        head_d   = head_q;
        tail_d   = tail_q;

        if (pop) begin
            bitmap_d[mem_q[head_q]] = 1'b0;
            head_d                  = next_ptr(head_q);
        end
        if (r_acc) begin
            mem_d[tail_q]   = r_idx;
            bitmap_d[r_idx] = 1'b1;
            tail_d          = next_ptr(tail_q);
        end
        b_slot = tail_d;
        if (b_acc) begin
            mem_d[b_slot]   = b_idx;
            bitmap_d[b_idx] = 1'b1;
            tail_d          = next_ptr(b_slot);
        end

        count_d = count_q + CNT_W'(r_acc) + CNT_W'(b_acc) - CNT_W'(pop);

        err_underflow_d   = err_underflow_q || (bus.alloc_req && (count_q == '0));
        err_double_free_d = err_double_free_q || r_dup || b_dup;
        err_range_d       = err_range_q || (r_live && !r_in_range) ||
                            (b_live && !b_in_range);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < RESET_CNT) ? IDX_W'(NUM_AREGS + 1 + i) : '0;
            end
            for (int i = 0; i < NUM_PREGS; i++) begin
                bitmap_q[i] <= (i > NUM_AREGS);
            end
            head_q            <= '0;
            tail_q            <= PTR_W'(RESET_CNT);
            count_q           <= CNT_W'(RESET_CNT);
            err_underflow_q   <= 1'b0;
            err_double_free_q <= 1'b0;
            err_range_q       <= 1'b0;
        end else begin
            mem_q             <= mem_d;
            bitmap_q          <= bitmap_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            err_underflow_q   <= err_underflow_d;
            err_double_free_q <= err_double_free_d;
            err_range_q       <= err_range_d;
        end
    end

    // Show-ahead head with no bypass: a push becomes visible the next cycle.
    assign bus.pr_out          = (count_q != '0) ? tag_t'(mem_q[head_q]) : TAG_NONE;
    assign bus.not_empty       = (count_q != '0);
    assign bus.free_count      = count_q;
    assign bus.err_underflow   = err_underflow_q;
    assign bus.err_double_free = err_double_free_q;
    assign bus.err_range       = err_range_q;

endmodule
